// File: rtl/single_bin_xcorr_if.sv
// Streaming bus for single_bin_xcorr: two aligned DFT bins in, integrated powers and
// cross-correlation out.
interface single_bin_xcorr_if #(
  parameter int unsigned DIN_WIDTH     = 32,
  parameter int unsigned ACC_WIDTH     = 80,
  parameter int unsigned ACC_LEN_WIDTH = 16
);
  logic signed [DIN_WIDTH-1:0] din0_re;
  logic signed [DIN_WIDTH-1:0] din0_im;
  logic signed [DIN_WIDTH-1:0] din1_re;
  logic signed [DIN_WIDTH-1:0] din1_im;
  logic                        din_valid;
  logic [ACC_LEN_WIDTH-1:0]    acc_len;
  logic [ACC_WIDTH-1:0]        pow0;
  logic [ACC_WIDTH-1:0]        pow1;
  logic signed [ACC_WIDTH-1:0] corr_re;
  logic signed [ACC_WIDTH-1:0] corr_im;
  logic                        dout_valid;
  logic                        acc_ovf;

  modport master (
    output din0_re, din0_im, din1_re, din1_im, din_valid, acc_len,
    input  pow0, pow1, corr_re, corr_im, dout_valid, acc_ovf
  );

  modport slave (
    input  din0_re, din0_im, din1_re, din1_im, din_valid, acc_len,
    output pow0, pow1, corr_re, corr_im, dout_valid, acc_ovf
  );
endinterface

// File: rtl/single_bin_xcorr.sv
// Single-bin two-antenna correlator: integrates |din0|^2, |din1|^2 and din0*conj(din1)
// over acc_len frames with saturating accumulators; 3-cycle latency, back-to-back integrations.
module single_bin_xcorr #(
  parameter int unsigned DIN_WIDTH     = 32,
  parameter int unsigned DIN_POINT     = 15,
  parameter int unsigned ACC_WIDTH     = 80,
  parameter int unsigned ACC_LEN_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  single_bin_xcorr_if.slave bus
);

  localparam int unsigned PW  = 2 * DIN_WIDTH + 1;
  localparam int unsigned AW  = ACC_WIDTH;
  localparam int unsigned ALW = ACC_LEN_WIDTH;

  if (ACC_WIDTH < PW || DIN_POINT >= DIN_WIDTH) begin : g_param_check
    $error("single_bin_xcorr: ACC_WIDTH must hold a full product and DIN_POINT < DIN_WIDTH");
  end

  // Result is {overflow, value}; unsigned sums clamp only at the top.
  function automatic logic [AW:0] sat_add_u(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AW] ? {1'b1, {AW{1'b1}}} : s;
  endfunction

  function automatic logic [AW:0] sat_add_s(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {a[AW-1], a} + {b[AW-1], b};
    return (s[AW] != s[AW-1]) ? {1'b1, s[AW], {(AW-1){~s[AW]}}} : {1'b0, s[AW-1:0]};
  endfunction

  // Stage 1: input registers
  logic                        s1_valid_q;
  logic signed [DIN_WIDTH-1:0] s1_re0_q, s1_im0_q, s1_re1_q, s1_im1_q;

  always_ff @(posedge clk) begin
    if (rst) s1_valid_q <= 1'b0;
    else     s1_valid_q <= bus.din_valid;
  end

  always_ff @(posedge clk) begin
    if (bus.din_valid) begin
      s1_re0_q <= bus.din0_re;
      s1_im0_q <= bus.din0_im;
      s1_re1_q <= bus.din1_re;
      s1_im1_q <= bus.din1_im;
    end
  end

  // Stage 2: full-precision products
  logic signed [PW-1:0] re0_x, im0_x, re1_x, im1_x;
  logic signed [PW-1:0] p0_d, p1_d, xr_d, xi_d;
  logic signed [PW-1:0] s2_p0_q, s2_p1_q, s2_xr_q, s2_xi_q;
  logic                 s2_valid_q;

  always_comb begin
    re0_x = PW'(s1_re0_q);
    im0_x = PW'(s1_im0_q);
    re1_x = PW'(s1_re1_q);
    im1_x = PW'(s1_im1_q);
    p0_d  = re0_x * re0_x + im0_x * im0_x;
    p1_d  = re1_x * re1_x + im1_x * im1_x;
    xr_d  = re0_x * re1_x + im0_x * im1_x;
    xi_d  = im0_x * re1_x - re0_x * im1_x;
  end

  always_ff @(posedge clk) begin
    if (rst) s2_valid_q <= 1'b0;
    else     s2_valid_q <= s1_valid_q;
  end

  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      s2_p0_q <= p0_d;
      s2_p1_q <= p1_d;
      s2_xr_q <= xr_d;
      s2_xi_q <= xi_d;
    end
  end

  // Stage 3: integration
  logic [ALW-1:0]       cnt_q, len_q, len_cur;
  logic                 first, last;
  logic [AW-1:0]        pow0_acc_q, pow1_acc_q, xr_acc_q, xi_acc_q;
  logic [AW-1:0]        base_p0, base_p1, base_xr, base_xi;
  logic [AW-1:0]        sum_p0, sum_p1, sum_xr, sum_xi;
  logic                 ovf_p0, ovf_p1, ovf_xr, ovf_xi;
  logic                 ovf_q, ovf_next;
  logic [AW-1:0]        pow0_q, pow1_q;
  logic signed [AW-1:0] corr_re_q, corr_im_q;
  logic                 dout_valid_q, acc_ovf_q;

  always_comb begin
    first   = (cnt_q == '0);
    len_cur = len_q;
    if (first) len_cur = (bus.acc_len == '0) ? ALW'(1) : bus.acc_len;
    last    = (cnt_q == len_cur - ALW'(1));

    // First product of an integration loads rather than sums.
    base_p0 = first ? '0 : pow0_acc_q;
    base_p1 = first ? '0 : pow1_acc_q;
    base_xr = first ? '0 : xr_acc_q;
    base_xi = first ? '0 : xi_acc_q;

    {ovf_p0, sum_p0} = sat_add_u(base_p0, AW'($unsigned(s2_p0_q)));
    {ovf_p1, sum_p1} = sat_add_u(base_p1, AW'($unsigned(s2_p1_q)));
    {ovf_xr, sum_xr} = sat_add_s(base_xr, AW'(s2_xr_q));
    {ovf_xi, sum_xi} = sat_add_s(base_xi, AW'(s2_xi_q));

    ovf_next = (~first & ovf_q) | ovf_p0 | ovf_p1 | ovf_xr | ovf_xi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      len_q        <= '0;
      pow0_acc_q   <= '0;
      pow1_acc_q   <= '0;
      xr_acc_q     <= '0;
      xi_acc_q     <= '0;
      ovf_q        <= 1'b0;
      pow0_q       <= '0;
      pow1_q       <= '0;
      corr_re_q    <= '0;
      corr_im_q    <= '0;
      dout_valid_q <= 1'b0;
      acc_ovf_q    <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (s2_valid_q) begin
        pow0_acc_q <= sum_p0;
        pow1_acc_q <= sum_p1;
        xr_acc_q   <= sum_xr;
        xi_acc_q   <= sum_xi;
        ovf_q      <= ovf_next;
        if (first) len_q <= len_cur;
        if (last) begin
          cnt_q        <= '0;
          pow0_q       <= sum_p0;
          pow1_q       <= sum_p1;
          corr_re_q    <= sum_xr;
          corr_im_q    <= sum_xi;
          dout_valid_q <= 1'b1;
          acc_ovf_q    <= ovf_next;
        end else begin
          cnt_q <= cnt_q + ALW'(1);
        end
      end
    end
  end

  assign bus.pow0       = pow0_q;
  assign bus.pow1       = pow1_q;
  assign bus.corr_re    = corr_re_q;
  assign bus.corr_im    = corr_im_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.acc_ovf    = acc_ovf_q;

endmodule

// File: doc/single_bin_xcorr.md
SINGLE_BIN_XCORR -- requirements
Module: single_bin_xcorr

Interface
REQ-001 The block SHALL have parameter DIN_WIDTH, default 32, giving the signed input width of each DFT component.
REQ-002 The block SHALL have parameter DIN_POINT, default 15, giving the input fractional bits.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 80, giving the accumulator and output width; the output point is 2*DIN_POINT.
REQ-004 The block SHALL have parameter ACC_LEN_WIDTH, default 16, giving the width of the integration-length input.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset: port clk, input, 1 bit, sole clock; port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have inputs din0_re and din0_im, each DIN_WIDTH bits signed, carrying the antenna-0 DFT bin.
REQ-007 The block SHALL have inputs din1_re and din1_im, each DIN_WIDTH bits signed, carrying the antenna-1 DFT bin.
REQ-008 The block SHALL have input din_valid, 1 bit, qualifying both bins together, which are always aligned.
REQ-009 The block SHALL have input acc_len, ACC_LEN_WIDTH bits unsigned, giving the number of DFT frames per integration.
REQ-010 The block SHALL have outputs pow0 and pow1, each ACC_WIDTH bits unsigned, carrying the integrated |din0|^2 and |din1|^2.
REQ-011 The block SHALL have outputs corr_re and corr_im, each ACC_WIDTH bits signed, carrying the integrated din0*conj(din1).
REQ-012 The block SHALL have output dout_valid, 1 bit, a one-cycle strobe marking a completed integration.
REQ-013 The block SHALL have output acc_ovf, 1 bit, valid with dout_valid, set when any accumulator saturated during that integration.

Function
REQ-014 Stage 1 SHALL register din*, din_valid.
REQ-015 Stage 2 SHALL register products: p0=re0^2+im0^2; p1=re1^2+im1^2; xr=re0*re1+im0*im1; xi=im0*re1-re0*im1; all at full width 2*DIN_WIDTH+1, with no rounding.
REQ-016 Stage 3 SHALL accumulate the sign-extended products on each valid product cycle; non-valid cycles hold all state.
REQ-017 A frame counter SHALL count valid products 0..L-1, where L is acc_len latched on the first valid product of each integration; acc_len changes mid-integration take effect at the next integration.
REQ-018 acc_len=0 SHALL be treated as L=1.
REQ-019 On the product with count==L-1, the outputs SHALL be loaded with accumulator+product, dout_valid SHALL be 1 for exactly one cycle, and the counter SHALL return to 0.
REQ-020 On the product with count==0, the accumulators SHALL be loaded with that product rather than summed, so integrations are back-to-back with no dead cycle and no sample dropped.
REQ-021 Latency SHALL be 3 cycles: a last sample presented at edge k produces dout_valid at edge k+3.
REQ-022 The accumulators SHALL saturate to the max/min ACC_WIDTH value instead of wrapping; pow0/pow1 SHALL saturate only high.
REQ-023 Any saturation SHALL set a sticky flag that clears at integration start; acc_ovf SHALL equal that flag, including the final sum, when dout_valid=1.
REQ-024 Outputs SHALL hold their last values between strobes.
REQ-025 din_valid gaps of any length inside an integration SHALL NOT alter the result.

Reset
REQ-026 While rst=1, the pipeline valids, the counter, the accumulators, the sticky flag, pow0, pow1, corr_re, corr_im, dout_valid and acc_ovf SHALL be 0.
REQ-027 Reset asserted mid-integration SHALL discard the partial sum; the first valid after release SHALL start a new integration with a freshly latched acc_len.
REQ-028 Samples in flight in stages 1-2 during reset SHALL be dropped.

Verification
REQ-029 The bench SHALL drive acc_len=4, 4 valid frames of din0=(1.0,0), din1=(0,1.0) and require, 3 cycles after the 4th frame, pow0=pow1=4.0, corr_re=0, corr_im=-4.0, acc_ovf=0, and dout_valid high for one cycle.
REQ-030 The bench SHALL drive acc_len=2 with 6 consecutive frames of din0=din1=(0.5,-0.5) and require 3 strobes spaced 2 cycles apart, each with pow0=pow1=corr_re=1.0 and corr_im=0.
REQ-031 The bench SHALL drive acc_len=0 with 3 frames and require 3 strobes, each equal to a single-frame product.
REQ-032 The bench SHALL drive acc_len=3 with din_valid toggling 1,0,0,1,0,1 and require results identical to 3 contiguous frames, with dout_valid only after the 3rd valid.
REQ-033 The bench SHALL use ACC_WIDTH=2*DIN_WIDTH+2, full-scale inputs and acc_len=8, and require pow0 = max unsigned and acc_ovf=1; the next clean integration SHALL give acc_ovf=0.
REQ-034 The bench SHALL assert rst after frame 2 of 4, then send 4 new frames, and require one strobe containing only the post-reset frames.
